array_20_ctrl: RTL and testbench
================================

Name: array_20_ctrl

Overview:
- Request sequencer directly upstream of the 4096x96 single-port array macro (12-bit address, 16 write-mask lanes of 6 bits, 1-cycle registered read).
- Converts a valid/ready request stream and a valid/ready response stream into the macro's RW0 port.
- Clears every array word after reset.
- Buffers read data so that response backpressure never loses a word.

Parameters:
- ADDR_W, 12, array address width; DEPTH = 2**ADDR_W.
- DATA_W, 96, word width.
- LANES, 16, write-mask lanes; lane width DATA_W/LANES = 6.
- CLEAR_ON_RESET, 1, when 1, run the clear sweep after reset.
- CLEAR_VALUE, 0, word value written by the clear sweep.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- req_write  in  1  1 = masked write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_mask  in  LANES  per-lane write enable; ignored on reads.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_W  read data, returned in request order.
- init_done  out  1  clear sweep finished; port open.
- RW0_addr  out  ADDR_W  to macro.
- RW0_en  out  1  to macro.
- RW0_wmode  out  1  to macro.
- RW0_wmask  out  LANES  to macro.
- RW0_wdata  out  DATA_W  to macro.
- RW0_rdata  in  DATA_W  from macro; valid the cycle after a read issue.

Behaviour:
- Reset, sampled at a clock edge:
  - FSM goes to CLEAR if CLEAR_ON_RESET, otherwise RUN.
  - clr_addr = 0, in-flight flag = 0, response FIFO emptied.
  - init_done = 0 (1 if CLEAR_ON_RESET = 0).
  - req_ready = 0, rsp_valid = 0, RW0_en = 0.
- Reset mid-operation behaves the same as reset from power-up:
  - any in-flight read is dropped and the FIFO is emptied.
  - a clear sweep restarts at address 0.
- CLEAR state:
  - Each cycle drives RW0_en = 1, RW0_wmode = 1, RW0_wmask = all ones, RW0_addr = clr_addr, RW0_wdata = CLEAR_VALUE.
  - clr_addr increments each cycle.
  - After writing DEPTH-1, go to RUN; no wrap-around write occurs.
  - The sweep takes exactly DEPTH cycles; init_done rises on the next cycle.
  - req_ready = 0 throughout.
- RUN state:
  - Ports are combinational pass-through from the request channel.
  - RW0_en = req_valid & req_ready.
  - RW0_wmode = req_write; RW0_addr, RW0_wmask and RW0_wdata follow the corresponding req_ signals.
- Write acceptance:
  - req_ready = 1 whenever in RUN.
  - A write produces no response.
- Read acceptance:
  - req_ready = 1 only if (fifo_count + inflight - pop) < 2, where pop = rsp_valid & rsp_ready.
  - This path is combinational from rsp_ready to req_ready and is allowed.
- Read data capture:
  - inflight <= 1 on the cycle after an accepted read.
  - In that cycle, RW0_rdata is pushed unconditionally into the 2-entry response FIFO; the credit rule guarantees space.
- Write after read, same address: a write issued in the capture cycle does not corrupt the captured data, because capture samples the old value at the edge.
- Read after write, same address: a read issued the cycle after a write returns the new data.
- Response FIFO:
  - 2 entries, in order; rsp_valid = (count != 0); rsp_rdata = head entry.
  - Push and pop in the same cycle keep count unchanged.
- Throughput: one read per cycle sustained while rsp_ready = 1; latency from request accept to rsp_valid is 2 cycles.
- Interleaving: any mix of reads and writes keeps request order; responses are read-only and in order.
- No RW0 access is driven outside an accept or clear cycle (RW0_en = 0).

Decomposition:
- Shared package array_20_pkg holds:
  - ADDR_W, DATA_W and LANES constants.
  - FSM state enum {CLEAR, RUN}.
  - Request struct {write, addr, mask, wdata}.
- One natural sub-module, array_20_rsp_fifo: 2-entry in-order FIFO with count output and simultaneous push/pop.
- The credit logic stays in the parent.

Test Plan:
- Reset, then idle:
  - init_done rises exactly 4096 cycles after reset deasserts.
  - Reads of addresses 0, 1234 and 4095 return 96'h0.
- Write addr 0x0A5, data all-ones, mask 16'h0001 over a zero word -> read returns 96'h3F.
- Write addr 7 with mask 16'h8000 -> only bits [95:90] change.
- Back-to-back reads of addr 1..8 with rsp_ready = 1 -> req_ready stays high and responses come in order, one per cycle, 2 cycles after each accept.
- rsp_ready = 0 while 5 reads are offered:
  - exactly 2 reads are accepted, then req_ready = 0.
  - Raising rsp_ready drains data in order with no loss or duplication.
- Read addr 9, then write addr 9 with 96'h5 the next cycle:
  - the response is the old value.
  - A following read returns 96'h5.
- Assert reset for 1 cycle mid-sweep at clr_addr 2000 and mid-read -> rsp_valid = 0, and the sweep restarts at address 0 with a full 4096-cycle duration.

Source files
------------

// File: rtl/array_20_pkg.sv
// Shared constants and types for the array_20 request sequencer.
package array_20_pkg;

    // Geometry of the single-port array macro.
    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned DATA_W     = 96;
    localparam int unsigned LANES      = 16;
    localparam int unsigned LANE_W     = DATA_W / LANES;
    localparam int unsigned DEPTH      = 2 ** ADDR_W;

    // Read responses that may be outstanding (captured plus in flight).
    localparam int unsigned FIFO_DEPTH = 2;

    // Controller phases: clear sweep after reset, then request pass-through.
    typedef enum logic [0:0] {
        StClear,
        StRun
    } state_e;

    // One request beat as seen on the request channel.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [LANES-1:0]  mask;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/array_20_rsp_fifo.sv
// Two-entry in-order response buffer with simultaneous push/pop and an
// occupancy count for the parent's credit logic.
module array_20_rsp_fifo
    import array_20_pkg::*;
#(
    parameter int unsigned WIDTH = array_20_pkg::DATA_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] rdata,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entries_q [FIFO_DEPTH];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             do_pop;

    // Pop only when something is held; push is never refused (the parent
    // only issues reads it has room for).
    always_comb begin
        do_pop  = pop & (count_q != 2'd0);
        count_d = count_q + {1'b0, push} - {1'b0, do_pop};
    end

    // Pointer and count state.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    // Data storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clock) begin
        if (push) begin
            entries_q[wr_ptr_q] <= wdata;
        end
    end

    assign valid = (count_q != 2'd0);
    assign rdata = entries_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/array_20_ctrl.sv
// Request sequencer in front of the 4096x96 single-port array macro.
// Clears the array after reset, then passes requests straight onto RW0 and
// buffers read data so response backpressure never drops a word.
module array_20_ctrl
    import array_20_pkg::*;
#(
    parameter int unsigned ADDR_W         = array_20_pkg::ADDR_W,
    parameter int unsigned DATA_W         = array_20_pkg::DATA_W,
    parameter int unsigned LANES          = array_20_pkg::LANES,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LANES-1:0]  req_mask,
    input  logic [DATA_W-1:0] req_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,

    output logic              init_done,

    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [LANES-1:0]  RW0_wmask,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] clr_addr_q;
    logic [ADDR_W-1:0] clr_addr_d;
    logic              inflight_q;
    logic              inflight_d;

    req_t              req;
    logic              accept;
    logic              pop;
    logic [1:0]        fifo_count;
    logic [2:0]        occupancy;
    logic              read_credit;

    assign req = '{write: req_write, addr: req_addr, mask: req_mask, wdata: req_wdata};

    // Read credit: buffered words plus the word coming out of the macro,
    // minus whatever the consumer takes this cycle, must leave a free slot.
    always_comb begin
        pop         = rsp_valid & rsp_ready;
        occupancy   = {1'b0, fifo_count} + {2'b00, inflight_q};
        read_credit = (occupancy - {2'b00, pop}) < 3'(FIFO_DEPTH);
    end

    // Next-state and RW0 drive: clear sweep, or request pass-through.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        req_ready  = 1'b0;
        accept     = 1'b0;
        RW0_en     = 1'b0;
        RW0_wmode  = 1'b0;
        RW0_addr   = '0;
        RW0_wmask  = '0;
        RW0_wdata  = '0;

        unique case (state_q)
            StClear: begin
                RW0_en     = 1'b1;
                RW0_wmode  = 1'b1;
                RW0_addr   = clr_addr_q;
                RW0_wmask  = '1;
                RW0_wdata  = CLEAR_VALUE;
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                // Last address written: leave without a wrap-around write.
                if (clr_addr_q == '1) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                req_ready = req.write | read_credit;
                accept    = req_valid & req_ready;
                RW0_en    = accept;
                RW0_wmode = req.write;
                RW0_addr  = req.addr;
                RW0_wmask = req.mask;
                RW0_wdata = req.wdata;
            end
            default: ;
        endcase

        // Nothing reaches the macro or the requester while reset is held.
        if (reset) begin
            req_ready = 1'b0;
            accept    = 1'b0;
            RW0_en    = 1'b0;
        end

        inflight_d = accept & ~req.write;
    end

    // Controller state; reset restarts the sweep and drops any in-flight read.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= CLEAR_ON_RESET ? StClear : StRun;
            clr_addr_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            inflight_q <= inflight_d;
        end
    end

    assign init_done = (state_q == StRun);

    // Macro read data is valid the cycle after issue; capture it unconditionally.
    array_20_rsp_fifo #(
        .WIDTH (DATA_W)
    ) u_rsp_fifo (
        .clock (clock),
        .reset (reset),
        .push  (inflight_q),
        .wdata (RW0_rdata),
        .pop   (pop),
        .valid (rsp_valid),
        .rdata (rsp_rdata),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_array_20_ctrl.sv
// Self-checking bench for array_20_ctrl: behavioural macro, shadow-memory
// scoreboard, table-driven vectors and directed multi-cycle sequences.
module tb_array_20_ctrl;

    localparam int AW = 12;
    localparam int DW = 96;
    localparam int LN = 16;
    localparam int NW = 4096;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [LN-1:0] req_mask;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic [AW-1:0] RW0_addr;
    logic          RW0_en, RW0_wmode;
    logic [LN-1:0] RW0_wmask;
    logic [DW-1:0] RW0_wdata, RW0_rdata;

    int total = 0;
    int bad   = 0;

    array_20_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_mask  (req_mask),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .RW0_addr  (RW0_addr),
        .RW0_en    (RW0_en),
        .RW0_wmode (RW0_wmode),
        .RW0_wmask (RW0_wmask),
        .RW0_wdata (RW0_wdata),
        .RW0_rdata (RW0_rdata)
    );

    always #5 clock = ~clock;

    task automatic check(input bit ok, input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [LN-1:0] m,
                                            input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = old;
        for (int l = 0; l < LN; l++) begin
            if (m[l]) r[l*6 +: 6] = d[l*6 +: 6];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] pat(input int a);
        return {32'(a), 32'hC0DE_0000 | 32'(a), 32'(a * 13 + 7)};
    endfunction

    // Behavioural macro: masked write, 1-cycle registered read.
    logic [DW-1:0] mem [NW];
    logic [DW-1:0] mac_rdata;
    assign RW0_rdata = mac_rdata;

    always @(posedge clock) begin
        if (RW0_en) begin
            if (RW0_wmode) mem[RW0_addr] = merge(mem[RW0_addr], RW0_wmask, RW0_wdata);
            else mac_rdata <= mem[RW0_addr];
        end
    end

    // Reference model: array contents, outstanding reads and their accept edge.
    logic [DW-1:0] shadow [NW];
    logic [DW-1:0] exp_q [$];
    int            acc_q [$];
    int            nedge = 0;
    bit            run_m = 0;
    bit            sb_valid, sb_pop, sb_ready, sb_acc;
    int            sb_pre;

    always @(posedge clock) nedge++;

    // Decide at the negedge what the coming edge must do, and check the DUT.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            acc_q.delete();
            for (int i = 0; i < NW; i++) shadow[i] = '0;
        end else if (run_m) begin
            sb_pre   = exp_q.size();
            sb_valid = (sb_pre > 0) && (nedge >= acc_q[0] + 1);
            sb_pop   = sb_valid && rsp_ready;
            check(rsp_valid === sb_valid, "sb_rsp_valid", rsp_valid, sb_valid);
            if (sb_pop) begin
                check(rsp_rdata === exp_q[0], "sb_rdata", rsp_rdata, exp_q[0]);
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
            end
            sb_ready = req_write || ((sb_pre - int'(sb_pop)) < 2);
            check(req_ready === sb_ready, "sb_req_ready", req_ready, sb_ready);
            sb_acc = req_valid && sb_ready;
            check(RW0_en === sb_acc, "sb_rw0_en", RW0_en, sb_acc);
            if (sb_acc) begin
                check(RW0_addr === req_addr && RW0_wmode === req_write &&
                      (!req_write || (RW0_wmask === req_mask && RW0_wdata === req_wdata)),
                      "sb_rw0_fields", RW0_addr, req_addr);
                if (req_write) begin
                    shadow[req_addr] = merge(shadow[req_addr], req_mask, req_wdata);
                end else begin
                    exp_q.push_back(shadow[req_addr]);
                    acc_q.push_back(nedge + 1);
                end
            end
        end
    end

    // Hold reset across one sampling edge, checking the gated outputs.
    task automatic pulse_reset();
        reset     = 1'b1;
        run_m     = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        @(negedge clock);
        check(req_ready === 1'b0, "reset_req_ready", req_ready, 0);
        check(RW0_en === 1'b0, "reset_rw0_en", RW0_en, 0);
        @(posedge clock); #1;
        reset     = 1'b0;
        req_write = 1'b1;
        req_addr  = '0;
        req_mask  = '1;
        req_wdata = {$urandom, $urandom, $urandom};
    endtask

    // Follow the clear sweep cycle by cycle, optionally stopping at abort_at.
    task automatic sweep(input int abort_at, output bit aborted);
        bit drive_bad = 0;
        bit done      = 0;
        int n         = 0;
        aborted = 0;
        while (n < 5000) begin
            @(negedge clock);
            if (init_done) begin
                done = 1;
                break;
            end
            if (!(RW0_en === 1'b1 && RW0_wmode === 1'b1 && RW0_wmask === 16'hFFFF &&
                  RW0_addr === n[11:0] && RW0_wdata === '0 && req_ready === 1'b0 &&
                  rsp_valid === 1'b0)) drive_bad = 1;
            if (n == abort_at) begin
                aborted = 1;
                break;
            end
            @(posedge clock); #1;
            req_valid = (n < 4000);
            n++;
        end
        check(!drive_bad, "sweep_drive", drive_bad, 0);
        if (!aborted) begin
            check(done && n == 4096, "init_done_cycle", n, 4096);
            run_m = 1'b1;
        end
        @(posedge clock); #1;
    endtask

    task automatic issue(input bit w, input logic [AW-1:0] a, input logic [LN-1:0] m,
                         input logic [DW-1:0] d);
        bit got = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_mask  = m;
        req_wdata = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (req_ready) begin
                got = 1;
                break;
            end
            @(posedge clock); #1;
        end
        check(got, "issue_accept", got, 1);
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [DW-1:0] d);
        bit got = 0;
        d = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (rsp_valid) begin
                got = 1;
                d   = rsp_rdata;
                break;
            end
            @(posedge clock); #1;
        end
        check(got, "rsp_timeout", got, 1);
        @(posedge clock); #1;
    endtask

    typedef struct {
        bit            write;
        logic [AW-1:0] addr;
        logic [LN-1:0] mask;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t          vecs [9];
    logic [DW-1:0] rx [$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] ones;
        logic [DW-1:0] top_lane;
        logic [DW-1:0] d;
        bit            ab;
        int            nxt;
        bit            bad_rdy, bad_rsp;

        ones     = '1;
        top_lane = '0;
        top_lane[95:90] = 6'h3F;
        for (int i = 0; i < NW; i++) mem[i] = {$urandom, $urandom, $urandom};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_mask  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        vecs[0] = '{0, 12'd0,    16'h0000, '0,        '0};
        vecs[1] = '{0, 12'd1234, 16'h0000, '0,        '0};
        vecs[2] = '{0, 12'd4095, 16'h0000, '0,        '0};
        vecs[3] = '{1, 12'h0A5,  16'h0001, ones,      '0};
        vecs[4] = '{0, 12'h0A5,  16'h0000, '0,        96'h3F};
        vecs[5] = '{1, 12'd7,    16'h8000, ones,      '0};
        vecs[6] = '{0, 12'd7,    16'h0000, '0,        top_lane};
        vecs[7] = '{1, 12'd9,    16'hFFFF, pat(9),    '0};
        vecs[8] = '{0, 12'd9,    16'h0000, '0,        pat(9)};

        pulse_reset();
        sweep(-1, ab);

        // Table-driven single transactions.
        for (int v = 0; v < 9; v++) begin
            issue(vecs[v].write, vecs[v].addr, vecs[v].mask, vecs[v].wdata);
            if (!vecs[v].write) begin
                wait_rsp(d);
                check(d === vecs[v].exp, $sformatf("vec%0d_rdata", v), d, vecs[v].exp);
            end
        end

        // Back-to-back reads of 1..8: one response per cycle, two cycles behind.
        for (int a = 1; a <= 8; a++) issue(1'b1, a[11:0], 16'hFFFF, pat(a));
        rsp_ready = 1'b1;
        bad_rdy   = 0;
        bad_rsp   = 0;
        for (int j = 0; j <= 10; j++) begin
            req_valid = (j < 8);
            req_write = 1'b0;
            req_addr  = 12'(j + 1);
            @(negedge clock);
            if (j < 8 && req_ready !== 1'b1) bad_rdy = 1;
            if (rsp_valid !== (j >= 2 && j <= 9)) bad_rsp = 1;
            if (j >= 2 && j <= 9 && rsp_rdata !== pat(j - 1)) bad_rsp = 1;
            @(posedge clock); #1;
        end
        req_valid = 1'b0;
        check(!bad_rdy, "tp_req_ready", bad_rdy, 0);
        check(!bad_rsp, "tp_rsp_timing", bad_rsp, 0);

        // Backpressure: only two reads fit, then drain in order.
        for (int a = 20; a < 25; a++) issue(1'b1, a[11:0], 16'hFFFF, pat(a));
        rsp_ready = 1'b0;
        nxt       = 0;
        for (int c = 0; c < 8; c++) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = 12'(20 + nxt);
            @(negedge clock);
            if (req_ready) nxt++;
            @(posedge clock); #1;
        end
        check(nxt == 2, "bp_accepted", nxt, 2);
        req_addr = 12'(20 + nxt);
        @(negedge clock);
        check(req_ready === 1'b0, "bp_ready_low", req_ready, 0);
        @(posedge clock); #1;
        rsp_ready = 1'b1;
        rx.delete();
        for (int c = 0; c < 40 && rx.size() < 5; c++) begin
            req_valid = (nxt < 5);
            req_addr  = 12'(20 + nxt);
            @(negedge clock);
            if (rsp_valid) rx.push_back(rsp_rdata);
            if (req_valid && req_ready) nxt++;
            @(posedge clock); #1;
        end
        req_valid = 1'b0;
        check(rx.size() == 5, "bp_count", rx.size(), 5);
        for (int i = 0; i < 5 && i < rx.size(); i++) begin
            check(rx[i] === pat(20 + i), $sformatf("bp_order%0d", i), rx[i], pat(20 + i));
        end
        @(negedge clock);
        check(rsp_valid === 1'b0, "bp_no_dup", rsp_valid, 0);
        @(posedge clock); #1;

        // Read 9, write 9 in the capture cycle, read 9 again.
        issue(1'b1, 12'd9, 16'hFFFF, pat(99));
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 12'd9;
        @(negedge clock);
        @(posedge clock); #1;
        req_write = 1'b1;
        req_mask  = 16'hFFFF;
        req_wdata = 96'h5;
        @(negedge clock);
        @(posedge clock); #1;
        req_write = 1'b0;
        @(negedge clock);
        @(posedge clock); #1;
        req_valid = 1'b0;
        wait_rsp(d);
        check(d === pat(99), "war_old_value", d, pat(99));
        wait_rsp(d);
        check(d === 96'h5, "raw_new_value", d, 96'h5);

        // Random mix against the scoreboard, on a small address window.
        for (int c = 0; c < 400; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_write = $urandom_range(0, 1);
            req_addr  = 12'($urandom_range(0, 15));
            req_mask  = 16'($urandom);
            req_wdata = {$urandom, $urandom, $urandom};
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clock); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        @(negedge clock);
        check(rsp_valid === 1'b0, "drain_rsp_valid", rsp_valid, 0);
        @(posedge clock); #1;

        // Reset with a read in flight, again mid-sweep at 2000, then a full sweep.
        rsp_ready = 1'b1;
        issue(1'b0, 12'd3, 16'h0000, '0);
        pulse_reset();
        sweep(2000, ab);
        check(ab, "abort_reached", ab, 1);
        pulse_reset();
        sweep(-1, ab);

        vecs[0].addr = 12'd0;
        vecs[1].addr = 12'd1234;
        vecs[2].addr = 12'd4095;
        for (int v = 0; v < 3; v++) begin
            issue(1'b0, vecs[v].addr, 16'h0000, '0);
            wait_rsp(d);
            check(d === '0, $sformatf("post_reset_rd%0d", v), d, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
